// File: rtl/sr_latch_driver_pkg.sv
// Shared types and helpers for the SR latch driver: FSM state encoding,
// command encoding and the drive-level mapping for NAND/NOR latch cells.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_t;

  // Active level is 0 for a NAND latch (ACTIVE_LOW=1) and 1 for a NOR latch;
  // the idle level is the complement.
  function automatic logic drv_level(input logic active_low, input logic active);
    if (active) begin
      return ~active_low;
    end else begin
      return active_low;
    end
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/status and latch-facing bundle of the SR latch driver.
// master = requester/latch side, slave = the driver itself.
interface sr_latch_driver_if;

  logic set_req;
  logic clr_req;
  logic q_fb;
  logic qb_fb;
  logic s_drv;
  logic r_drv;
  logic ready;
  logic done;
  logic q_model;
  logic fb_err;

  modport master (
    output set_req, clr_req, q_fb, qb_fb,
    input  s_drv, r_drv, ready, done, q_model, fb_err
  );

  modport slave (
    input  set_req, clr_req, q_fb, qb_fb,
    output s_drv, r_drv, ready, done, q_model, fb_err
  );

endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer with synchronous reset for the latch feedback lines,
// which toggle asynchronously to clk.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Synchronous front-end for a cross-coupled SR latch: converts single-cycle
// set/clear requests into fixed-width drive pulses followed by an idle gap,
// never drives S and R active together, and checks latch feedback against
// the expected state while idle.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int PULSE_W    = 3,
  parameter int GAP_W      = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit SET_PRIO   = 1'b0,
  parameter bit INIT_CLR   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  sr_latch_driver_if.slave bus
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW    = $clog2(MAX_W + 1);

  // Counter holds the remaining cycles after the current one, so 0 marks the
  // last cycle of a phase.
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  localparam logic L_ACT  = drv_level(ACTIVE_LOW, 1'b1);
  localparam logic L_IDLE = drv_level(ACTIVE_LOW, 1'b0);

  localparam state_t ST_RESET = INIT_CLR ? ST_INIT : ST_IDLE;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  cmd_t          r_cmd;
  cmd_t          w_cmd_next;
  logic          r_init;
  logic          w_init_next;
  logic          w_accept;

  logic r_s_drv;
  logic r_r_drv;
  logic r_ready;
  logic r_done;
  logic r_q_model;
  logic r_fb_err;

  logic w_s_next;
  logic w_r_next;
  logic w_ready_next;
  logic w_done_next;
  logic w_qm_next;
  logic w_err_next;

  logic w_q_sync;
  logic w_qb_sync;

  sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .i_d (bus.q_fb),
    .o_q (w_q_sync)
  );

  sync2 u_sync_qb (
    .clk (clk),
    .rst (rst),
    .i_d (bus.qb_fb),
    .o_q (w_qb_sync)
  );

  // State register together with the phase counter and the latched command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
      r_cnt   <= {CW{1'b0}};
      r_cmd   <= CMD_CLR;
      r_init  <= INIT_CLR;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cmd   <= w_cmd_next;
      r_init  <= w_init_next;
    end
  end

  // Next-state logic: command acceptance, phase sequencing and counter reloads.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cmd_next   = r_cmd;
    w_init_next  = r_init;
    w_accept     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_next = ST_PULSE;
        w_cnt_next   = PULSE_LD;
        w_cmd_next   = CMD_CLR;
        w_init_next  = 1'b1;
      end
      ST_IDLE: begin
        if (bus.set_req || bus.clr_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LD;
          w_init_next  = 1'b0;
          if (bus.set_req && bus.clr_req) begin
            w_cmd_next = SET_PRIO ? CMD_SET : CMD_CLR;
          end else if (bus.set_req) begin
            w_cmd_next = CMD_SET;
          end else begin
            w_cmd_next = CMD_CLR;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = ST_GAP;
          w_cnt_next   = GAP_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop that
  // lines up with the state it describes.
  always_comb begin
    w_s_next     = L_IDLE;
    w_r_next     = L_IDLE;
    w_ready_next = 1'b0;
    w_done_next  = 1'b0;
    w_qm_next    = r_q_model;
    w_err_next   = r_fb_err;

    if (w_state_next == ST_PULSE) begin
      if (w_cmd_next == CMD_SET) begin
        w_s_next = L_ACT;
      end else begin
        w_r_next = L_ACT;
      end
    end else begin
      w_s_next = L_IDLE;
      w_r_next = L_IDLE;
    end

    w_ready_next = (w_state_next == ST_IDLE);
    w_done_next  = (r_state == ST_GAP) && (w_state_next == ST_IDLE) && !r_init;

    if (r_state == ST_INIT) begin
      w_qm_next = 1'b0;
    end else if (w_accept) begin
      w_qm_next = (w_cmd_next == CMD_SET);
    end else begin
      w_qm_next = r_q_model;
    end

    // Feedback is only trusted in IDLE, after the gap has let the latch and
    // synchronizers settle.
    if ((r_state == ST_IDLE) &&
        ((w_q_sync != r_q_model) || (w_q_sync == w_qb_sync))) begin
      w_err_next = 1'b1;
    end else begin
      w_err_next = r_fb_err;
    end
  end

  // Output registers; reset parks both latch inputs at the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_drv   <= L_IDLE;
      r_r_drv   <= L_IDLE;
      r_ready   <= ~INIT_CLR;
      r_done    <= 1'b0;
      r_q_model <= 1'b0;
      r_fb_err  <= 1'b0;
    end else begin
      r_s_drv   <= w_s_next;
      r_r_drv   <= w_r_next;
      r_ready   <= w_ready_next;
      r_done    <= w_done_next;
      r_q_model <= w_qm_next;
      r_fb_err  <= w_err_next;
    end
  end

  assign bus.s_drv   = r_s_drv;
  assign bus.r_drv   = r_r_drv;
  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.q_model = r_q_model;
  assign bus.fb_err  = r_fb_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Table-driven bench for sr_latch_driver. Three instances share stimulus:
// A = NAND latch, clear priority; B = NAND latch, set priority;
// C = NOR latch, clear priority. Each drives a behavioural SR latch whose
// outputs feed back; A's feedback can be forced to the illegal Q=QB=1.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_set = 1'b0;
  logic t_clr = 1'b0;
  logic t_bad = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_driver_if ifa ();
  sr_latch_driver_if ifb ();
  sr_latch_driver_if ifc ();

  sr_latch_driver #(.PULSE_W(3), .GAP_W(2), .ACTIVE_LOW(1'b1), .SET_PRIO(1'b0), .INIT_CLR(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sr_latch_driver #(.PULSE_W(3), .GAP_W(2), .ACTIVE_LOW(1'b1), .SET_PRIO(1'b1), .INIT_CLR(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  sr_latch_driver #(.PULSE_W(3), .GAP_W(2), .ACTIVE_LOW(1'b0), .SET_PRIO(1'b0), .INIT_CLR(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // Behavioural latches: NAND for A/B (active low), NOR for C (active high)
  logic lq_a = 1'b1;
  logic lq_b = 1'b1;
  logic lq_c = 1'b1;

  always @* begin
    if (!ifa.s_drv && ifa.r_drv) lq_a = 1'b1;
    else if (ifa.s_drv && !ifa.r_drv) lq_a = 1'b0;
  end
  always @* begin
    if (!ifb.s_drv && ifb.r_drv) lq_b = 1'b1;
    else if (ifb.s_drv && !ifb.r_drv) lq_b = 1'b0;
  end
  always @* begin
    if (ifc.s_drv && !ifc.r_drv) lq_c = 1'b1;
    else if (!ifc.s_drv && ifc.r_drv) lq_c = 1'b0;
  end

  assign ifa.set_req = t_set;
  assign ifa.clr_req = t_clr;
  assign ifa.q_fb    = t_bad ? 1'b1 : lq_a;
  assign ifa.qb_fb   = t_bad ? 1'b1 : ~lq_a;
  assign ifb.set_req = t_set;
  assign ifb.clr_req = t_clr;
  assign ifb.q_fb    = lq_b;
  assign ifb.qb_fb   = ~lq_b;
  assign ifc.set_req = t_set;
  assign ifc.clr_req = t_clr;
  assign ifc.q_fb    = lq_c;
  assign ifc.qb_fb   = ~lq_c;

  // in = {rst,set,clr,bad}; a = A's {s,r,ready,done,q_model,fb_err}
  // after the edge; b = B's {s,r,q_model}. B shares A's ready/done and never
  // errs; C equals A with s/r inverted and never errs.
  typedef struct packed {
    logic [3:0] in;
    logic [5:0] a;
    logic [2:0] b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] in, input logic [5:0] a, input logic [2:0] b);
    vec_t v;
    v.in = in;
    v.a  = a;
    v.b  = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (ifa.s_drv == 1'b0 && ifa.r_drv == 1'b0) begin
      errors++;
      $display("FAIL inv_a both active s=%b r=%b required not both 0", ifa.s_drv, ifa.r_drv);
    end
    checks++;
    if (ifb.s_drv == 1'b0 && ifb.r_drv == 1'b0) begin
      errors++;
      $display("FAIL inv_b both active s=%b r=%b required not both 0", ifb.s_drv, ifb.r_drv);
    end
    checks++;
    if (ifc.s_drv == 1'b1 && ifc.r_drv == 1'b1) begin
      errors++;
      $display("FAIL inv_c both active s=%b r=%b required not both 1", ifc.s_drv, ifc.r_drv);
    end
  endtask

  initial begin
    logic [5:0] got_a;
    logic [5:0] got_b;
    logic [5:0] got_c;
    logic [5:0] exp_b;
    logic [5:0] exp_c;
    int cnt;

    // reset
    tbl.push_back(mk(4'b1000, 6'b110000, 3'b110));
    tbl.push_back(mk(4'b1000, 6'b110000, 3'b110));
    // INIT clear pulse, gap, idle without done
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0000, 6'b100000, 3'b100));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b110000, 3'b110));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b111000, 3'b110));
    // set, with a clear request during the pulse that must be ignored
    tbl.push_back(mk(4'b0100, 6'b010010, 3'b011));
    tbl.push_back(mk(4'b0010, 6'b010010, 3'b011));
    tbl.push_back(mk(4'b0000, 6'b010010, 3'b011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b110010, 3'b111));
    tbl.push_back(mk(4'b0000, 6'b111110, 3'b111));
    tbl.push_back(mk(4'b0000, 6'b111010, 3'b111));
    // simultaneous set+clear: A/C clear wins, B set wins
    tbl.push_back(mk(4'b0110, 6'b100000, 3'b011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b100000, 3'b011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b110000, 3'b111));
    tbl.push_back(mk(4'b0000, 6'b111100, 3'b111));
    tbl.push_back(mk(4'b0000, 6'b111000, 3'b111));
    // set, aborted by reset in the second pulse cycle, then INIT again
    tbl.push_back(mk(4'b0100, 6'b010010, 3'b011));
    tbl.push_back(mk(4'b0000, 6'b010010, 3'b011));
    tbl.push_back(mk(4'b1000, 6'b110000, 3'b110));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0000, 6'b100000, 3'b100));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b110000, 3'b110));
    tbl.push_back(mk(4'b0000, 6'b111000, 3'b110));
    // force Q=QB=1 on A's feedback in IDLE: error after sync latency, sticky
    tbl.push_back(mk(4'b0001, 6'b111000, 3'b110));
    tbl.push_back(mk(4'b0001, 6'b111000, 3'b110));
    tbl.push_back(mk(4'b0001, 6'b111001, 3'b110));
    tbl.push_back(mk(4'b0000, 6'b111001, 3'b110));
    tbl.push_back(mk(4'b0100, 6'b010011, 3'b011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b010011, 3'b011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 6'b110011, 3'b111));
    tbl.push_back(mk(4'b0000, 6'b111111, 3'b111));
    // only reset clears the sticky error
    tbl.push_back(mk(4'b1000, 6'b110000, 3'b110));
    tbl.push_back(mk(4'b0000, 6'b100000, 3'b100));

    for (int i = 0; i < tbl.size(); i++) begin
      rst   = tbl[i].in[3];
      t_set = tbl[i].in[2];
      t_clr = tbl[i].in[1];
      t_bad = tbl[i].in[0];
      tick();
      got_a = {ifa.s_drv, ifa.r_drv, ifa.ready, ifa.done, ifa.q_model, ifa.fb_err};
      got_b = {ifb.s_drv, ifb.r_drv, ifb.ready, ifb.done, ifb.q_model, ifb.fb_err};
      got_c = {ifc.s_drv, ifc.r_drv, ifc.ready, ifc.done, ifc.q_model, ifc.fb_err};
      exp_b = {tbl[i].b[2], tbl[i].b[1], tbl[i].a[3], tbl[i].a[2], tbl[i].b[0], 1'b0};
      exp_c = {~tbl[i].a[5], ~tbl[i].a[4], tbl[i].a[3], tbl[i].a[2], tbl[i].a[1], 1'b0};
      checks++;
      if (got_a !== tbl[i].a) begin
        errors++;
        $display("FAIL row%0d_a got %b required %b", i, got_a, tbl[i].a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL row%0d_b got %b required %b", i, got_b, exp_b);
      end
      checks++;
      if (got_c !== exp_c) begin
        errors++;
        $display("FAIL row%0d_c got %b required %b", i, got_c, exp_c);
      end
    end
    rst   = 1'b0;
    t_set = 1'b0;
    t_clr = 1'b0;
    t_bad = 1'b0;

    // Held clear request: wait for ready, accept, then measure latency to done
    cnt = 0;
    while (!ifa.ready && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (!ifa.ready) begin
      errors++;
      $display("FAIL wait_ready got %b required 1 within 20 cycles", ifa.ready);
    end
    t_clr = 1'b1;
    tick();
    t_clr = 1'b0;
    checks++;
    if (ifa.r_drv !== 1'b0 || ifa.ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_clr got r=%b ready=%b required r=0 ready=0", ifa.r_drv, ifa.ready);
    end
    cnt = 0;
    while (!ifa.done && cnt < 10) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("FAIL done_latency got %0d required 5 cycles after acceptance", cnt);
    end
    checks++;
    if ({ifa.q_model, ifa.fb_err, ifb.q_model, ifb.done, ifc.done} !== 5'b00011) begin
      errors++;
      $display("FAIL after_clr got %b required 00011 (qmA errA qmB doneB doneC)",
               {ifa.q_model, ifa.fb_err, ifb.q_model, ifb.done, ifc.done});
    end
    tick();
    checks++;
    if (ifa.done !== 1'b0 || ifa.ready !== 1'b1) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b ready=%b required done=0 ready=1", ifa.done, ifa.ready);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous front-end that sits directly upstream of the cross-coupled SR latch cells (2-input and 3-input variants).
- Turns single-cycle set/clear requests into clean, minimum-width latch drive pulses.
- Never drives the forbidden S=R active combination.
- Tracks the expected latch state and checks it against the latch's Q/QB feedback, raising a sticky error on disagreement or on Q==QB.

Parameters:
- PULSE_W, 3, number of cycles S or R is held active per command (>=1)
- GAP_W, 2, number of cycles both inputs are held inactive after a pulse (>=2, covers feedback synchronizer latency)
- ACTIVE_LOW, 1, 1 = NAND-style latch (active level 0, idle S=R=1); 0 = NOR-style (active level 1, idle S=R=0)
- SET_PRIO, 0, policy when set_req and clr_req arrive together: 1 = set wins, 0 = clear wins
- INIT_CLR, 1, 1 = issue one automatic clear pulse after reset release

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- set_req  in  1  request a set pulse; sampled only when ready=1
- clr_req  in  1  request a clear pulse; sampled only when ready=1
- q_fb  in  1  latch Q output (asynchronous to clk)
- qb_fb  in  1  latch QB output (asynchronous to clk)
- s_drv  out  1  registered latch S input
- r_drv  out  1  registered latch R input
- ready  out  1  FSM in IDLE and able to accept a request
- done  out  1  one-cycle pulse when a command completes (return to IDLE)
- q_model  out  1  expected latch state
- fb_err  out  1  sticky feedback mismatch flag

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset state:
  - s_drv = r_drv = idle level (1 if ACTIVE_LOW, else 0)
  - ready=0, done=0, q_model=0, fb_err=0
  - synchronizer flops = 0, counter = 0
  - state = INIT if INIT_CLR=1, else IDLE (ready=1 on the first cycle after reset in that case)
- rst asserted mid-pulse aborts the pulse: outputs return to idle on the next edge.
- States: INIT, IDLE, PULSE, GAP.
- INIT:
  - Loads a clear command: r_drv active for PULSE_W cycles.
  - q_model set to 0.
  - Proceeds to GAP, then IDLE.
  - done is not pulsed for the INIT sequence.
- IDLE:
  - ready=1.
  - On an edge with set_req or clr_req high: latch the command, set q_model (1 for set, 0 for clear), go to PULSE, ready falls.
  - If both requests are high, SET_PRIO selects the winner; the other request is dropped, not queued.
  - If neither is high, remain in IDLE.
- PULSE:
  - Exactly one of s_drv/r_drv is at the active level for exactly PULSE_W cycles, starting the cycle after acceptance. Then go to GAP.
- GAP:
  - Both outputs idle for GAP_W cycles. Then go to IDLE with done=1 for one cycle.
- Latency: request accepted at edge N → drive active in cycles N+1..N+PULSE_W → ready=1 and done=1 at cycle N+PULSE_W+GAP_W+1.
- Requests while ready=0 are ignored; the requester must hold or re-issue.
- Invariant: s_drv and r_drv are never both at the active level in any cycle, including during reset.
- Feedback check:
  - q_fb and qb_fb pass through 2-flop synchronizers.
  - In IDLE only, fb_err is set if sync(q_fb) != q_model or sync(q_fb) == sync(qb_fb).
  - fb_err is cleared only by rst.
  - No check is made in INIT, PULSE or GAP.
- Counter: one down-counter of width $clog2(max(PULSE_W,GAP_W)+1), reloaded on each state entry. No wrap is permitted; reaching 0 triggers the transition.

Decomposition:
- Shared package sr_pkg holds:
  - state enum typedef (INIT, IDLE, PULSE, GAP)
  - cmd enum (CMD_SET, CMD_CLR)
  - function returning the active/idle drive level from ACTIVE_LOW
- One sub-module, sync2: two-flop synchronizer with synchronous reset, instantiated twice for q_fb and qb_fb.
- The FSM and counter stay in the top module.

Test Plan:
- Reset release, INIT_CLR=1, PULSE_W=3, GAP_W=2, ACTIVE_LOW=1 → r_drv=0 for cycles 1-3, ready=1 at cycle 6, done stays 0, q_model=0.
- set_req pulse accepted at cycle 10 → s_drv=0 in cycles 11-13, s_drv=r_drv=1 in 14-15, done=1 and ready=1 at cycle 16, q_model=1.
- set_req=clr_req=1 with SET_PRIO=0 → only r_drv pulses, q_model=0; repeat with SET_PRIO=1 → only s_drv pulses, q_model=1. Assert every cycle that s_drv and r_drv are never both 0.
- clr_req asserted during PULSE of a set → ignored, no second pulse. rst at second cycle of PULSE → s_drv=r_drv=1 next edge and q_model=0.
- Latch model connected with q_fb correct → fb_err=0. Force q_fb=qb_fb=1 in IDLE → fb_err=1 within 3 cycles and stays 1 until rst.
- ACTIVE_LOW=0, set then clear → s_drv=1 for 3 cycles, later r_drv=1 for 3 cycles, idle level 0 otherwise.
